// File: rtl/mmio_axi_master_if.sv
// rtl/mmio_axi_master_if.sv - core MMIO request/response and AXI4-Lite bundle for mmio_axi_master
//
// Purpose: groups the core-side request/response handshake and the five
// AXI4-Lite channels into one interface.
// Modports:
//   master - view of mmio_axi_master (drives req_ready/resp_*, AXI valids, addresses, write data, rready/bready)
//   slave  - view of the core plus device register file (drives req_*, AXI readies, read data, responses)
`timescale 1ns/1ps
interface mmio_axi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output axi_araddr, axi_arvalid, input axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid, output axi_rready,
        output axi_awaddr, axi_awvalid, input axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
        input  axi_bresp, axi_bvalid, output axi_bready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  axi_araddr, axi_arvalid, output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid, input axi_rready,
        input  axi_awaddr, axi_awvalid, output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
        output axi_bresp, axi_bvalid, input axi_bready
    );
endinterface

// File: rtl/mmio_axi_master.sv
// rtl/mmio_axi_master.sv - single-outstanding AXI4-Lite initiator for core MMIO loads/stores
//
// Purpose: accepts one 32-bit load/store at a time from the core and runs it
// as an AXI4-Lite read or write, returning a one-cycle resp_valid pulse with
// read data and an error flag. All outputs are registered.
// Ports:
//   clk  - clock
//   rstn - synchronous, active-low reset
//   bus  - mmio_axi_master_if.master (request/response + AR/R/AW/W/B channels)
// Optional feature: define AXI_TIMEOUT_EN to abort any phase stalled for
// TIMEOUT_CYCLES cycles (response with err=1, rdata=32'hFFFF_FFFF).
`timescale 1ns/1ps
module mmio_axi_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    mmio_axi_master_if.master  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_hs, w_hs;

`ifdef AXI_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
`endif

    assign aw_hs = awvalid_q & bus.axi_awready;
    assign w_hs  = wvalid_q & bus.axi_wready;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (bus.req_we) begin
                        awaddr_d  = bus.req_addr;
                        wdata_d   = bus.req_wdata;
                        wstrb_d   = bus.req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR_REQ;
                    end else begin
                        araddr_d  = bus.req_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && bus.axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rready_q && bus.axi_rvalid) begin
                    rready_d     = 1'b0;
                    resp_rdata_d = bus.axi_rdata;
                    resp_err_d   = (bus.axi_rresp != 2'b00);
                    resp_valid_d = 1'b1;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Use this cycle's handshakes too, so a last phase finishing
                // in the same cycle moves straight on to the B phase.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bready_q && bus.axi_bvalid) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = (bus.axi_bresp != 2'b00);
                    resp_valid_d = 1'b1;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AXI_TIMEOUT_EN
        // A handshake that lands on the last allowed cycle still wins: the
        // abort only fires when the phase made no progress.
        tmo_d = tmo_q + 16'd1;
        if (state_q == S_IDLE || state_d != state_q) begin
            tmo_d = 16'd0;
        end else if (tmo_q == TMO_LAST) begin
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'hFFFF_FFFF;
            req_ready_d  = 1'b1;
            state_d      = S_IDLE;
            tmo_d        = 16'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            araddr_q     <= 32'h0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= 32'h0;
            awvalid_q    <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

`ifdef AXI_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn) tmo_q <= 16'd0;
        else       tmo_q <= tmo_d;
    end
`endif

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.axi_araddr  = araddr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_rready  = rready_q;
    assign bus.axi_awaddr  = awaddr_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = wstrb_q;
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_bready  = bready_q;
endmodule

// File: tb/tb_mmio_axi_master.sv
// tb/tb_mmio_axi_master.sv - self-checking bench for mmio_axi_master
`timescale 1ns/1ps
module tb_mmio_axi_master;
    localparam int TMO = 16;
`ifdef AXI_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int STALL = 1 << 30;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mmio_axi_master_if bus();
    mmio_axi_master #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Transaction-level reference: one request in flight, phase flags, expected response.
    bit          chk_en = 1'b0;
    bit          busy = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          ar_seen, aw_seen, w_seen;
    bit          resp_due = 1'b0;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          age = 0;
    bit          rst_prev = 1'b1;
    typedef struct { int c; logic [31:0] d; logic e; } resp_t;
    resp_t       resp_q[$];
    int          acc_q[$];

    // Observations handed to the slave driver.
    bit s_rst = 1'b1, s_ar_v, s_ar_hs, s_r_hs, s_aw_v, s_aw_hs, s_w_v, s_w_hs, s_b_hs;

    always @(negedge clk) begin
        bit e_arv, e_rr, e_awv, e_wv, e_br, prog;
        s_rst   = !rstn;
        s_ar_v  = bus.axi_arvalid === 1'b1;
        s_ar_hs = s_ar_v && bus.axi_arready;
        s_r_hs  = (bus.axi_rready === 1'b1) && bus.axi_rvalid;
        s_aw_v  = bus.axi_awvalid === 1'b1;
        s_aw_hs = s_aw_v && bus.axi_awready;
        s_w_v   = bus.axi_wvalid === 1'b1;
        s_w_hs  = s_w_v && bus.axi_wready;
        s_b_hs  = (bus.axi_bready === 1'b1) && bus.axi_bvalid;
        if (chk_en) begin
            if (rst_prev) begin
                chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
                chk("rst_flags", 32'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid, bus.axi_wvalid,
                                      bus.axi_bready, bus.resp_valid, bus.resp_err}), 32'd0);
                chk("rst_araddr", bus.axi_araddr, 32'd0);
                chk("rst_awaddr", bus.axi_awaddr, 32'd0);
                chk("rst_wdata", bus.axi_wdata, 32'd0);
                chk("rst_wstrb", 32'(bus.axi_wstrb), 32'd0);
                chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
            end
            e_arv = busy && !m_we && !ar_seen;
            e_rr  = busy && !m_we && ar_seen;
            e_awv = busy && m_we && !aw_seen;
            e_wv  = busy && m_we && !w_seen;
            e_br  = busy && m_we && aw_seen && w_seen;
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("resp_valid", 32'(bus.resp_valid), 32'(resp_due));
            if (resp_due) begin
                chk("resp_rdata", bus.resp_rdata, exp_rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
            end
            if (bus.resp_valid === 1'b1) resp_q.push_back('{cyc, bus.resp_rdata, bus.resp_err});
            chk("ar_r_aw_w_b", 32'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready}),
                32'({e_arv, e_rr, e_awv, e_wv, e_br}));
            if (e_arv) chk("araddr", bus.axi_araddr, m_addr);
            if (e_awv) chk("awaddr", bus.axi_awaddr, m_addr);
            if (e_wv) begin
                chk("wdata", bus.axi_wdata, m_wdata);
                chk("wstrb", 32'(bus.axi_wstrb), 32'(m_wstrb));
            end

            resp_due = 1'b0;
            if (!rstn) begin
                busy = 1'b0;
                age  = 0;
            end else if (!busy) begin
                if (bus.req_valid) begin
                    busy = 1'b1; m_we = bus.req_we; m_addr = bus.req_addr;
                    m_wdata = bus.req_wdata; m_wstrb = bus.req_wstrb;
                    ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; age = 0;
                    acc_q.push_back(cyc);
                end
            end else begin
                prog = 1'b0;
                if (e_arv && bus.axi_arready) begin
                    ar_seen = 1'b1; prog = 1'b1;
                end else if (e_rr && bus.axi_rvalid) begin
                    resp_due = 1'b1; exp_rdata = bus.axi_rdata; exp_err = (bus.axi_rresp != 2'b00);
                    busy = 1'b0; prog = 1'b1;
                end
                if (e_awv && bus.axi_awready) aw_seen = 1'b1;
                if (e_wv && bus.axi_wready) w_seen = 1'b1;
                if (m_we && !e_br && aw_seen && w_seen) prog = 1'b1;
                if (e_br && bus.axi_bvalid) begin
                    resp_due = 1'b1; exp_rdata = 32'd0; exp_err = (bus.axi_bresp != 2'b00);
                    busy = 1'b0; prog = 1'b1;
                end
                if (prog) age = 0;
                else begin
                    age++;
                    if (TMO_ON && age == TMO) begin
                        resp_due = 1'b1; exp_rdata = 32'hFFFF_FFFF; exp_err = 1'b1; busy = 1'b0; age = 0;
                    end
                end
            end
        end
        rst_prev = !rstn;
    end

    // AXI-Lite slave: readies after a per-channel delay counted in cycles of valid.
    bit          rnd_mode = 1'b0;
    int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    int          d_ar = 0, d_r = 0, d_aw = 0, d_w = 0, d_b = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit          rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_rresp, cur_bresp;
    logic [31:0] dir_rdata_q[$];
    logic [1:0]  dir_rresp_q[$];
    logic [1:0]  dir_bresp_q[$];

    function automatic int rdly();
        return int'($urandom_range(0, 3));
    endfunction
    function automatic logic [1:0] rresp_pick();
        return (rnd_mode && $urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    endfunction

    always @(posedge clk) begin
        #1;
        if (s_rst) begin
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        end else begin
            if (s_r_hs) rd_pend = 0; else if (rd_pend) r_cnt++;
            if (s_ar_hs) begin
                ar_cnt = 0; d_ar = rdly(); rd_pend = 1; r_cnt = 0; d_r = rdly();
                cur_rdata = (dir_rdata_q.size() > 0) ? dir_rdata_q.pop_front() : $urandom;
                cur_rresp = (dir_rresp_q.size() > 0) ? dir_rresp_q.pop_front() : rresp_pick();
            end else if (s_ar_v) ar_cnt++;
            if (s_b_hs) b_pend = 0; else if (b_pend) b_cnt++;
            if (s_aw_hs) begin aw_got = 1; aw_cnt = 0; d_aw = rdly(); end else if (s_aw_v) aw_cnt++;
            if (s_w_hs) begin w_got = 1; w_cnt = 0; d_w = rdly(); end else if (s_w_v) w_cnt++;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; d_b = rdly();
                cur_bresp = (dir_bresp_q.size() > 0) ? dir_bresp_q.pop_front() : rresp_pick();
            end
        end
        bus.axi_arready = ar_cnt >= (rnd_mode ? d_ar : cfg_ar);
        bus.axi_awready = aw_cnt >= (rnd_mode ? d_aw : cfg_aw);
        bus.axi_wready  = w_cnt >= (rnd_mode ? d_w : cfg_w);
        bus.axi_rvalid  = rd_pend ? (r_cnt >= (rnd_mode ? d_r : cfg_r)) : (rnd_mode && $urandom_range(0, 3) == 0);
        bus.axi_rdata   = rd_pend ? cur_rdata : $urandom;
        bus.axi_rresp   = rd_pend ? cur_rresp : 2'($urandom);
        bus.axi_bvalid  = b_pend ? (b_cnt >= (rnd_mode ? d_b : cfg_b)) : (rnd_mode && $urandom_range(0, 3) == 0);
        bus.axi_bresp   = b_pend ? cur_bresp : 2'($urandom);
    end

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit hold);
        int  n0 = acc_q.size();
        bit  ok = 1'b0;
        bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (acc_q.size() > n0) begin ok = 1'b1; break; end
        end
        if (!ok) expire("accept");
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output resp_t r);
        bit ok = 1'b0;
        r = '{0, 32'hx, 1'bx};
        for (int i = 0; i < 3000; i++) begin
            if (resp_q.size() > 0) begin r = resp_q.pop_front(); ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) expire("response");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t r1, r2;
        int    c0, c1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
        repeat (3) @(posedge clk);
        #1; rstn = 1'b1; chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: zero-wait read, response on cycle 3
        dir_rdata_q.push_back(32'h7472_6976);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        c0 = acc_q[$];
        wait_resp(r1);
        chk("t1_latency", 32'(r1.c - c0), 32'd3);
        chk("t1_rdata", r1.d, 32'h7472_6976);
        chk("t1_err", 32'(r1.e), 32'd0);

        // 2: W completes three cycles before AW
        cfg_aw = 3;
        issue(1'b1, 32'h70, 32'h0000_000F, 4'hF, 1'b0);
        c0 = acc_q[$];
        wait_resp(r1);
        chk("t2_latency", 32'(r1.c - c0), 32'd6);
        chk("t2_rdata", r1.d, 32'd0);
        chk("t2_err", 32'(r1.e), 32'd0);
        cfg_aw = 0;

        // 3: error responses
        dir_bresp_q.push_back(2'b10);
        issue(1'b1, 32'h50, 32'h1234_5678, 4'h0, 1'b0);
        wait_resp(r1);
        chk("t3_bresp_err", 32'(r1.e), 32'd1);
        dir_rdata_q.push_back(32'hDEAD_0001);
        dir_rresp_q.push_back(2'b11);
        issue(1'b0, 32'h54, 32'h0, 4'h0, 1'b0);
        wait_resp(r1);
        chk("t3_rresp_err", 32'(r1.e), 32'd1);
        chk("t3_rdata", r1.d, 32'hDEAD_0001);

        // 4: req_valid held for two back-to-back reads
        dir_rdata_q.push_back(32'h1);
        dir_rdata_q.push_back(32'h2);
        issue(1'b0, 32'h04, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 32'h08, 32'h0, 4'h0, 1'b0);
        c1 = acc_q[$];
        wait_resp(r1);
        wait_resp(r2);
        chk("t4_first", r1.d, 32'h1);
        chk("t4_second", r2.d, 32'h2);
        chk("t4_accept_on_resp", 32'(c1), 32'(r1.c));

        // 5: reset pulse while waiting in the R phase
        cfg_r = 1000;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("t5_rready", 32'(bus.axi_rready), 32'd0);
        chk("t5_arvalid", 32'(bus.axi_arvalid), 32'd0);
        chk("t5_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_resp_valid", 32'(bus.resp_valid), 32'd0);
        rstn = 1'b1;
        cfg_r = 0;
        @(posedge clk); #1;
        chk("t5_no_stray_resp", 32'(resp_q.size()), 32'd0);
        dir_rdata_q.push_back(32'hA5A5_5A5A);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b0);
        wait_resp(r1);
        chk("t5_after_reset", r1.d, 32'hA5A5_5A5A);

        // 6: AR never accepted
        cfg_ar = STALL;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        c0 = acc_q[$];
`ifdef AXI_TIMEOUT_EN
        wait_resp(r1);
        chk("t6_latency", 32'(r1.c - c0), 32'(TMO + 1));
        chk("t6_rdata", r1.d, 32'hFFFF_FFFF);
        chk("t6_err", 32'(r1.e), 32'd1);
        cfg_ar = 0;
`else
        repeat (1000) @(posedge clk);
        #1;
        chk("t6_arvalid_held", 32'(bus.axi_arvalid), 32'd1);
        chk("t6_no_resp", 32'(resp_q.size()), 32'd0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        cfg_ar = 0;
`endif
        @(posedge clk); #1;

        // Randomized traffic, checked cycle by cycle against the reference
        resp_q.delete();
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom), $urandom, $urandom, 4'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        for (int i = 0; i < 200 && (busy || resp_due); i++) begin
            @(posedge clk); #1;
        end
        if (busy || resp_due) expire("drain");
        @(posedge clk); #1;
        chk("rand_resp_count", 32'(resp_q.size()), 32'd300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
